// File: rtl/fadd_sub_pipe.sv
// Three-stage IEEE-754 adder/subtractor: S1 unpack/align, S2 add/LZC, S3 normalise/round/pack.
// Global stall: every stage holds whenever the output register is full and not being taken.
module fadd_sub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     op1,
  input  logic [EXP_W+MAN_W:0]     op2,
  input  logic                     sub,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     flag_ovf,
  output logic                     flag_unf,
  output logic                     flag_inv
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW  = MAN_W + 5;
  localparam int LZW = $clog2(MW + 1);
  localparam int EW  = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

  logic w_adv;

  // ---------------- S1: unpack / align ----------------
  logic               w_sa, w_sb;
  logic [EXP_W-1:0]   w_ea, w_eb;
  logic [MAN_W-1:0]   w_ma, w_mb;
  logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_big;
  logic               w_sign_big;
  logic [EXP_W-1:0]   w_e_big, w_e_sml, w_shamt;
  logic [MAN_W-1:0]   w_m_big, w_m_sml;
  logic [MW-1:0]      w_mant_big, w_sml_raw, w_mant_sml;
  logic               w_nan, w_inf, w_inf_sign;

  assign w_sa = op1[W-1];
  assign w_sb = op2[W-1] ^ sub;
  assign w_ea = op1[W-2:MAN_W];
  assign w_eb = op2[W-2:MAN_W];
  // Denormals are flushed: a zero exponent forces a zero magnitude.
  assign w_ma = (w_ea == '0) ? '0 : op1[MAN_W-1:0];
  assign w_mb = (w_eb == '0) ? '0 : op2[MAN_W-1:0];

  assign w_a_nan = (&w_ea) & (|op1[MAN_W-1:0]);
  assign w_b_nan = (&w_eb) & (|op2[MAN_W-1:0]);
  assign w_a_inf = (&w_ea) & ~(|op1[MAN_W-1:0]);
  assign w_b_inf = (&w_eb) & ~(|op2[MAN_W-1:0]);
  assign w_nan   = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa != w_sb));
  assign w_inf   = w_a_inf | w_b_inf;
  assign w_inf_sign = w_a_inf ? w_sa : w_sb;

  assign w_a_big = {w_ea, w_ma} >= {w_eb, w_mb};

  always_comb begin
    w_sign_big = w_sb;
    w_e_big    = w_eb;
    w_e_sml    = w_ea;
    w_m_big    = w_mb;
    w_m_sml    = w_ma;
    if (w_a_big) begin
      w_sign_big = w_sa;
      w_e_big    = w_ea;
      w_e_sml    = w_eb;
      w_m_big    = w_ma;
      w_m_sml    = w_mb;
    end
  end

  assign w_shamt    = w_e_big - w_e_sml;
  assign w_mant_big = {1'b0, |w_e_big, w_m_big, 3'b000};
  assign w_sml_raw  = {1'b0, |w_e_sml, w_m_sml, 3'b000};

  always_comb begin
    if (32'(w_shamt) >= 32'(MAN_W + 3))
      w_mant_sml = {{(MW-1){1'b0}}, |w_sml_raw};
    else
      w_mant_sml = (w_sml_raw >> w_shamt) |
                   {{(MW-1){1'b0}}, |(w_sml_raw & ~({MW{1'b1}} << w_shamt))};
  end

  logic               r1_valid;
  logic [TAG_W-1:0]   r1_tag;
  logic               r1_sign, r1_effsub, r1_nan, r1_inf, r1_inf_sign;
  logic [EXP_W-1:0]   r1_exp;
  logic [MW-1:0]      r1_mbig, r1_msml;

  // ---------------- S2: add / leading-zero count ----------------
  logic [MW-1:0]      w2_sum;
  logic [LZW-1:0]     w2_lzc;

  assign w2_sum = r1_effsub ? (r1_mbig - r1_msml) : (r1_mbig + r1_msml);

  always_comb begin
    w2_lzc = LZW'(MW);
    for (int unsigned i = 0; i < MW; i++)
      if (w2_sum[i]) w2_lzc = LZW'(MW - 1 - i);
  end

  logic               r2_valid;
  logic [TAG_W-1:0]   r2_tag;
  logic               r2_sign, r2_effsub, r2_nan, r2_inf, r2_inf_sign;
  logic [EXP_W-1:0]   r2_exp;
  logic [MW-1:0]      r2_sum;
  logic [LZW-1:0]     r2_lzc;

  // ---------------- S3: normalise / round / pack ----------------
  logic [MW-2:0]          w3_norm;
  logic signed [EW-1:0]   w3_exp;
  logic                   w3_inc;
  logic [MAN_W+1:0]       w3_rnd;
  logic [MAN_W-1:0]       w3_man;
  logic [W-1:0]           w3_res;
  logic                   w3_ovf, w3_unf, w3_inv;

  always_comb begin
    w3_exp = {2'b00, r2_exp};
    if (r2_sum[MW-1]) begin
      w3_norm = {r2_sum[MW-1:2], r2_sum[1] | r2_sum[0]};
      w3_exp  = w3_exp + EW'(1);
    end else begin
      w3_norm = (MW-1)'(r2_sum << (r2_lzc - 1'b1));
      w3_exp  = w3_exp - EW'(r2_lzc) + EW'(1);
    end
    w3_inc = w3_norm[2] & (w3_norm[1] | w3_norm[0] | w3_norm[3]);
    w3_rnd = {1'b0, w3_norm[MW-2:3]} + (MAN_W+2)'(w3_inc);
    w3_man = w3_rnd[MAN_W-1:0];
    if (w3_rnd[MAN_W+1]) begin
      w3_exp = w3_exp + EW'(1);
      w3_man = w3_rnd[MAN_W:1];
    end

    w3_ovf = 1'b0;
    w3_unf = 1'b0;
    w3_inv = 1'b0;
    w3_res = {r2_sign, w3_exp[EXP_W-1:0], w3_man};
    if (r2_nan) begin
      w3_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      w3_inv = 1'b1;
    end else if (r2_inf) begin
      w3_res = {r2_inf_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (r2_sum == '0) begin
      // Cancellation gives +0; only a true add of two like-signed zeros keeps the sign.
      w3_res = {r2_sign & ~r2_effsub, {(W-1){1'b0}}};
    end else if (w3_exp >= EXP_MAX) begin
      w3_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w3_ovf = 1'b1;
    end else if (w3_exp[EW-1] || (w3_exp == '0)) begin
      w3_res = {r2_sign, {(W-1){1'b0}}};
      w3_unf = 1'b1;
    end
  end

  logic               r3_valid;
  logic [TAG_W-1:0]   r3_tag;
  logic [W-1:0]       r3_result;
  logic               r3_ovf, r3_unf, r3_inv;

  assign w_adv = ~r3_valid | out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_valid  <= 1'b0;
      r2_valid  <= 1'b0;
      r3_valid  <= 1'b0;
      r3_tag    <= '0;
      r3_result <= '0;
      r3_ovf    <= 1'b0;
      r3_unf    <= 1'b0;
      r3_inv    <= 1'b0;
    end else if (w_adv) begin
      r1_valid  <= in_valid;
      r2_valid  <= r1_valid;
      r3_valid  <= r2_valid;
      r3_tag    <= r2_tag;
      r3_result <= w3_res;
      r3_ovf    <= w3_ovf;
      r3_unf    <= w3_unf;
      r3_inv    <= w3_inv;
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r1_tag      <= in_tag;
      r1_sign     <= w_sign_big;
      r1_effsub   <= w_sa ^ w_sb;
      r1_nan      <= w_nan;
      r1_inf      <= w_inf;
      r1_inf_sign <= w_inf_sign;
      r1_exp      <= w_e_big;
      r1_mbig     <= w_mant_big;
      r1_msml     <= w_mant_sml;

      r2_tag      <= r1_tag;
      r2_sign     <= r1_sign;
      r2_effsub   <= r1_effsub;
      r2_nan      <= r1_nan;
      r2_inf      <= r1_inf;
      r2_inf_sign <= r1_inf_sign;
      r2_exp      <= r1_exp;
      r2_sum      <= w2_sum;
      r2_lzc      <= w2_lzc;
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r3_valid;
  assign result    = r3_result;
  assign out_tag   = r3_tag;
  assign flag_ovf  = r3_ovf;
  assign flag_unf  = r3_unf;
  assign flag_inv  = r3_inv;

endmodule

// File: tb/tb_fadd_sub_pipe.sv
// Directed bench for fadd_sub_pipe: single-precision instance plus a half-precision instance.
module tb_fadd_sub_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] op1, op2, result;
  logic [3:0]  in_tag, out_tag;
  logic        flag_ovf, flag_unf, flag_inv;

  logic        h_in_valid, h_in_ready, h_sub, h_out_valid, h_out_ready;
  logic [15:0] h_op1, h_op2, h_result;
  logic [3:0]  h_in_tag, h_out_tag;
  logic        h_flag_ovf, h_flag_unf, h_flag_inv;

  int errors = 0;
  int checks = 0;

  fadd_sub_pipe u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .sub(sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag),
    .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inv(flag_inv)
  );

  fadd_sub_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) u_half (
    .clk(clk), .reset(reset),
    .in_valid(h_in_valid), .in_ready(h_in_ready),
    .op1(h_op1), .op2(h_op2), .sub(h_sub), .in_tag(h_in_tag),
    .out_valid(h_out_valid), .out_ready(h_out_ready),
    .result(h_result), .out_tag(h_out_tag),
    .flag_ovf(h_flag_ovf), .flag_unf(h_flag_unf), .flag_inv(h_flag_inv)
  );

  // Issue one operation on an idle pipe and wait (bounded) for its result.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [3:0] tag, output logic [31:0] res,
                       output logic [3:0] otag, output logic [2:0] flags, output int lat);
    @(negedge clk);
    op1 = a; op2 = b; sub = s; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = result; otag = out_tag; flags = {flag_ovf, flag_unf, flag_inv};
  endtask

  task automatic do_half(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output logic [2:0] flags, output int lat);
    @(negedge clk);
    h_op1 = a; h_op2 = b; h_sub = 1'b0; h_in_tag = 4'h3; h_in_valid = 1'b1; h_out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    h_in_valid = 1'b0;
    while (!h_out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = h_result; flags = {h_flag_ovf, h_flag_unf, h_flag_inv};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; op1 = '0; op2 = '0; sub = 1'b0; in_tag = '0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_op1 = '0; h_op2 = '0; h_sub = 1'b0; h_in_tag = '0; h_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h want=00000000", result); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_tag got=%h want=0", out_tag); end
    checks++;
    if ({flag_ovf, flag_unf, flag_inv} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b want=000", {flag_ovf, flag_unf, flag_inv});
    end
    checks++; if (h_out_valid !== 1'b0) begin errors++; $display("FAIL reset_half_valid got=%b want=0", h_out_valid); end
  endtask

  task automatic test_basic();
    logic [31:0] r; logic [3:0] t; logic [2:0] f; int lat;
    do_op(32'h3F800000, 32'h40000000, 1'b0, 4'd5, r, t, f, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency got=%0d want=3", lat); end
    checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL basic_result got=%h want=40400000", r); end
    checks++; if (t !== 4'd5) begin errors++; $display("FAIL basic_tag got=%0d want=5", t); end
    checks++; if (f !== 3'b000) begin errors++; $display("FAIL basic_flags got=%b want=000", f); end
  endtask

  // Flag vector order is {ovf, unf, inv}.
  task automatic test_arith();
    logic [31:0] va [10] = '{32'h3F800000, 32'h3F800001, 32'h3F800000, 32'h3F800000, 32'h80000000,
                             32'h00800001, 32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001, 32'h00000001};
    logic [31:0] vb [10] = '{32'h3F800000, 32'h33800000, 32'h33800000, 32'h3FC00000, 32'h80000000,
                             32'h00800000, 32'h7F7FFFFF, 32'hFF800000, 32'h3F800000, 32'h00000000};
    logic        vs [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] ve [10] = '{32'h00000000, 32'h3F800002, 32'h3F800000, 32'hBF000000, 32'h80000000,
                             32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h00000000};
    logic [2:0]  vf [10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                             3'b010, 3'b100, 3'b001, 3'b001, 3'b000};
    string       vn [10] = '{"cancel", "tie_even_up", "tie_even_down", "sub_neg", "negzero",
                             "underflow", "overflow", "inf_minus_inf", "nan_in", "denormal"};
    logic [31:0] r; logic [3:0] t; logic [2:0] f; int lat;
    for (int i = 0; i < 10; i++) begin
      do_op(va[i], vb[i], vs[i], 4'(i), r, t, f, lat);
      checks++;
      if (r !== ve[i]) begin errors++; $display("FAIL %s_result got=%h want=%h", vn[i], r, ve[i]); end
      checks++;
      if (f !== vf[i]) begin errors++; $display("FAIL %s_flags got=%b want=%b", vn[i], f, vf[i]); end
    end
  endtask

  task automatic test_inf_pass();
    logic [31:0] r; logic [3:0] t; logic [2:0] f; int lat;
    do_op(32'h3F800000, 32'h7F800000, 1'b1, 4'd9, r, t, f, lat);
    checks++; if (r !== 32'hFF800000) begin errors++; $display("FAIL inf_pass_result got=%h want=ff800000", r); end
    checks++; if (f !== 3'b000) begin errors++; $display("FAIL inf_pass_flags got=%b want=000", f); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vb [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h3F000000};
    logic [31:0] ve [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                            32'h40C00000, 32'h40E00000, 32'h41000000, 32'h3FC00000};
    int sent = 0;
    int rcv = 0;
    int extra = 0;
    logic exp_rdy;
    for (int c = 0; c < 40 && rcv < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 7);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        op1 = 32'h3F800000; op2 = vb[sent]; sub = 1'b0; in_tag = 4'(sent);
      end
      #1;
      exp_rdy = !(c >= 4 && c <= 7);
      if (c < 12) begin
        checks++;
        if (in_ready !== exp_rdy) begin errors++; $display("FAIL b2b_in_ready c=%0d got=%b want=%b", c, in_ready, exp_rdy); end
      end
      if (out_valid) begin
        checks++;
        if (result !== ve[rcv] || out_tag !== 4'(rcv)) begin
          errors++;
          $display("FAIL b2b_result c=%0d got=%h/%0d want=%h/%0d", c, result, out_tag, ve[rcv], rcv);
        end
        if (out_ready) rcv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (rcv !== 8) begin errors++; $display("FAIL b2b_count got=%0d want=8", rcv); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_extra got=%0d want=0", extra); end
  endtask

  task automatic test_reset_flush();
    int stale = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; op1 = 32'h3F800000; op2 = 32'h3F800000; sub = 1'b0; in_tag = 4'hA;
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b want=1", in_ready); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL flush_result got=%h want=00000000", result); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL flush_stale got=%0d want=0", stale); end
  endtask

  task automatic test_half();
    logic [15:0] r; logic [2:0] f; int lat;
    do_half(16'h3C00, 16'h3C00, r, f, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL half_latency got=%0d want=3", lat); end
    checks++; if (r !== 16'h4000) begin errors++; $display("FAIL half_add_result got=%h want=4000", r); end
    checks++; if (f !== 3'b000) begin errors++; $display("FAIL half_add_flags got=%b want=000", f); end
    do_half(16'h7BFF, 16'h7BFF, r, f, lat);
    checks++; if (r !== 16'h7C00) begin errors++; $display("FAIL half_ovf_result got=%h want=7c00", r); end
    checks++; if (f !== 3'b100) begin errors++; $display("FAIL half_ovf_flags got=%b want=100", f); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_inf_pass();
    test_back_to_back();
    test_reset_flush();
    test_half();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
